// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - minifloat {sign, exp[2:0], frac[3:0]} constants and divider state encoding
package fp8_pkg;

  localparam int EXP_W  = 3;
  localparam int FRAC_W = 4;
  localparam int BIAS   = 3;
  localparam int QBITS  = FRAC_W + 3;
  localparam int MANT_W = FRAC_W + 1;
  localparam int REM_W  = FRAC_W + 2;
  localparam int SE_W   = EXP_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [EXP_W+FRAC_W-1:0] SAT_MAG   = '1;
  localparam logic [EXP_W+FRAC_W-1:0] FLUSH_MAG = '0;

  function automatic logic [EXP_W+FRAC_W:0] pack_fp(input logic s,
                                                    input logic [EXP_W-1:0] e,
                                                    input logic [FRAC_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/mant_div_step.sv
// rtl/mant_div_step.sv - one restoring division step: compare/subtract divisor, then shift for the next bit
module mant_div_step
  import fp8_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [MANT_W-1:0] divisor,
  output logic [REM_W-1:0]  rem_next,
  output logic              qbit
);

  logic [REM_W-1:0] diff;

  // After a restoring subtract the remainder is below the divisor, so the shift never loses its MSB.
  always_comb begin
    qbit     = (rem >= {1'b0, divisor});
    diff     = qbit ? (rem - {1'b0, divisor}) : rem;
    rem_next = {diff[REM_W-2:0], 1'b0};
  end

endmodule

// File: rtl/floating_divider.sv
// rtl/floating_divider.sv - sequential minifloat divider; ROUND_NEAREST_EN selects round-half-even over truncation
module floating_divider
  import fp8_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    S1,
  input  logic [EXP_W-1:0]        E1,
  input  logic [FRAC_W-1:0]       F1,
  input  logic                    S2,
  input  logic [EXP_W-1:0]        E2,
  input  logic [FRAC_W-1:0]       F2,
  output logic [EXP_W+FRAC_W:0]   Fout,
  output logic                    done1,
  output logic                    busy,
  output logic                    ovf,
  output logic                    unf
);

  localparam int CNT_W = $clog2(QBITS + 1);
  localparam logic signed [SE_W-1:0] E_MAX = SE_W'((1 << EXP_W) - 1);

  state_t state, state_next;

  logic [MANT_W-1:0]       a_mant, b_mant;
  logic                    sign;
  logic signed [SE_W-1:0]  exp_q, exp_in;
  logic [REM_W-1:0]        rem, rem_step;
  logic [QBITS-1:0]        quo;
  logic [CNT_W-1:0]        cnt;
  logic                    qbit;

  logic [FRAC_W-1:0]       m_t, m_r;
  logic                    g_t, st_t;
  logic signed [SE_W-1:0]  e_t, e_r;
  logic [EXP_W+FRAC_W:0]   res;
  logic                    res_ovf, res_unf;

  assign exp_in = SE_W'(E1) - SE_W'(E2) + SE_W'(BIAS);

  mant_div_step u_step (
    .rem      (rem),
    .divisor  (b_mant),
    .rem_next (rem_step),
    .qbit     (qbit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (cnt == CNT_W'(QBITS)) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done1 = (state == DONE);
  assign busy  = (state == DIV) || (state == NORM);

  // The quotient of two 1.f mantissas lies in (0.5, 2): at most one left shift.
  always_comb begin
    if (quo[QBITS-1]) begin
      m_t  = quo[QBITS-2 -: FRAC_W];
      g_t  = quo[1];
      st_t = quo[0] | (|rem);
      e_t  = exp_q;
    end else begin
      m_t  = quo[QBITS-3 -: FRAC_W];
      g_t  = quo[0];
      st_t = |rem;
      e_t  = exp_q - SE_W'(1);
    end
  end

`ifdef ROUND_NEAREST_EN
  logic [FRAC_W:0] m_inc;

  always_comb begin
    m_inc = {1'b0, m_t} + (FRAC_W+1)'(1);
    m_r   = m_t;
    e_r   = e_t;
    if (g_t & (st_t | m_t[0])) begin
      m_r = m_inc[FRAC_W-1:0];
      if (m_inc[FRAC_W]) e_r = e_t + SE_W'(1);
    end
  end
`else
  logic unused_round;

  assign unused_round = g_t ^ st_t;
  assign m_r = m_t;
  assign e_r = e_t;
`endif

  always_comb begin
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res     = pack_fp(sign, e_r[EXP_W-1:0], m_r);
    if (e_r > E_MAX) begin
      res_ovf = 1'b1;
      res     = {sign, SAT_MAG};
    end else if (e_r[SE_W-1]) begin
      res_unf = 1'b1;
      res     = {sign, FLUSH_MAG};
    end
  end

  // DIV cycle 0 loads the dividend; cycles 1..QBITS each emit one quotient bit, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Fout   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      a_mant <= '0;
      b_mant <= '0;
      sign   <= 1'b0;
      exp_q  <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_mant <= {1'b1, F1};
            b_mant <= {1'b1, F2};
            sign   <= S1 ^ S2;
            exp_q  <= exp_in;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == '0) begin
            rem <= rem | REM_W'(a_mant);
          end else begin
            rem <= rem_step;
            quo <= {quo[QBITS-2:0], qbit};
          end
        end
        NORM: begin
          Fout <= res;
          ovf  <= res_ovf;
          unf  <= res_unf;
        end
        default: ;
      endcase
    end
  end

endmodule
